// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side handshake.
// stall_i=1 means decode holds this cycle and the stage must keep its outputs; jmp_taken_i overrides it.
interface fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall_i;
  logic               jmp_taken_i;
  logic [ADDR_W-1:0]  jmp_target_i;
  logic [INSTR_W-1:0] if_instr_o;
  logic [ADDR_W-1:0]  if_pc_o;
  logic               if_valid_o;
  logic [1:0]         op_o;
  logic [1:0]         inst_o;

  modport master (
    output imem_addr, if_instr_o, if_pc_o, if_valid_o, op_o, inst_o,
    input  imem_rdata, stall_i, jmp_taken_i, jmp_target_i
  );

  modport slave (
    input  imem_addr, if_instr_o, if_pc_o, if_valid_o, op_o, inst_o,
    output imem_rdata, stall_i, jmp_taken_i, jmp_target_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-cycle imem request slot (F1) and decode output register.
// Optional FETCH_PERF_EN adds fetched-instruction and bubble counters.
module fetch_stage #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst,
    fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_bubble_cnt_o
`endif
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  f1_pc_q, f1_pc_d;
    logic               f1_valid_q, f1_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic               out_valid_q, out_valid_d;

    // A stall re-reads the in-flight address so imem_rdata still matches F1 on release.
    always_comb begin
        bus.imem_addr = pc_q;
        if (rst) begin
            bus.imem_addr = RESET_PC;
        end else if (bus.jmp_taken_i) begin
            bus.imem_addr = bus.jmp_target_i;
        end else if (bus.stall_i) begin
            bus.imem_addr = f1_pc_q;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        f1_pc_d     = f1_pc_q;
        f1_valid_d  = f1_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        if (bus.jmp_taken_i) begin
            f1_pc_d     = bus.jmp_target_i;
            f1_valid_d  = 1'b1;
            pc_d        = bus.jmp_target_i + 1'b1;
            out_valid_d = 1'b0;
        end else if (!bus.stall_i) begin
            out_instr_d = bus.imem_rdata;
            out_pc_d    = f1_pc_q;
            out_valid_d = f1_valid_q;
            f1_pc_d     = pc_q;
            f1_valid_d  = 1'b1;
            pc_d        = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            f1_pc_q     <= '0;
            f1_valid_q  <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            f1_pc_q     <= f1_pc_d;
            f1_valid_q  <= f1_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.if_instr_o = out_instr_q;
    assign bus.if_pc_o    = out_pc_q;
    assign bus.if_valid_o = out_valid_q;

    // Bubbles decode as a no-op: op=00, inst=10.
    always_comb begin
        bus.op_o   = 2'b00;
        bus.inst_o = 2'b10;
        if (out_valid_q) begin
            bus.op_o   = out_instr_q[INSTR_W-1:INSTR_W-2];
            bus.inst_o = out_instr_q[INSTR_W-3:INSTR_W-4];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_d && (bus.jmp_taken_i || !bus.stall_i)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (!out_valid_d && (bus.jmp_taken_i || !bus.stall_i)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt_o  = fetch_cnt_q;
    assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the vector ASIP pipeline, directly upstream of the control unit.
- Owns the PC and drives the synchronous instruction memory, which has 1-cycle read latency.
- Registers the fetched word and presents the op/inst decode fields to the control unit.
- Handles decode stall and jump redirect; a jump costs one bubble.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width.
- INSTR_W, 32, instruction width; op = instr[INSTR_W-1:INSTR_W-2], inst = instr[INSTR_W-3:INSTR_W-4].
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  instruction memory read address (combinational from internal state).
- imem_rdata  in  INSTR_W  word for the address presented the previous cycle.
- stall_i  in  1  downstream cannot accept; hold the stage.
- jmp_taken_i  in  1  jump resolved taken for the instruction currently in decode.
- jmp_target_i  in  ADDR_W  jump destination word address.
- if_instr_o  out  INSTR_W  registered instruction to decode.
- if_pc_o  out  ADDR_W  address of if_instr_o.
- if_valid_o  out  1  if_instr_o is a real instruction.
- op_o  out  2  op field to control unit.
- inst_o  out  2  inst field to control unit.

Behaviour:
- Internal state:
  - pc: next fetch address.
  - f1_pc, f1_valid: request in flight; imem_rdata belongs to it.
  - Output register: if_instr_o, if_pc_o, if_valid_o.
- Reset (rst=1, overrides everything):
  - pc=RESET_PC, f1_valid=0, f1_pc=0.
  - if_valid_o=0, if_instr_o=0, if_pc_o=0.
  - imem_addr=RESET_PC during reset.
- Latency:
  - The first rising edge with rst=0 issues RESET_PC.
  - if_valid_o=1 with instr@RESET_PC after the second edge.
- Normal cycle (no jump, stall_i=0):
  - imem_addr=pc.
  - Output regs <= {imem_rdata, f1_pc, f1_valid}.
  - f1_pc<=pc, f1_valid<=1, pc<=pc+1.
  - Steady state gives one instruction per cycle.
- Stall (stall_i=1, jmp_taken_i=0):
  - Output regs, f1 and pc hold.
  - imem_addr=f1_pc, so the re-read returns the same in-flight word next cycle. No instruction is lost or duplicated.
- Jump (jmp_taken_i=1):
  - Has priority over stall_i.
  - imem_addr=jmp_target_i combinationally that cycle.
  - f1_pc<=jmp_target_i, f1_valid<=1, pc<=jmp_target_i+1.
  - if_valid_o<=0; the wrong-path word in F1 is discarded.
  - Target instruction appears in decode 2 edges after the jump edge (1 bubble).
- Bubble encoding: when if_valid_o=0, op_o=2'b00, inst_o=2'b10, decoding as a no-op (no memory, register or jump effect). When if_valid_o=1, op_o/inst_o are the fields of if_instr_o.
- Arithmetic:
  - PC is word-addressed; increment is +1 modulo 2^ADDR_W (0xFFFF -> 0x0000 for ADDR_W=16).
  - jmp_target_i+1 wraps likewise.
- Reset mid-stall or mid-jump returns to the reset state; pending redirect is dropped.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, add ports:
  - perf_fetch_cnt_o  out  32  increments on each edge that loads the output register with a valid instruction (not stalled, no jump, f1_valid=1).
  - perf_bubble_cnt_o  out  32  increments on each non-stalled edge that loads if_valid_o=0.
- Both counters reset to 0, wrap at 2^32, and hold during stall.
- When undefined, the ports and counters are absent; fetch behaviour is identical.

Test Plan:
- Reset then run, imem[i]=0x1000_0000+i -> if_valid_o=1 with if_pc_o=0, instr 0x1000_0000 after 2nd edge post-reset; then pc 1,2,3 on consecutive cycles.
- stall_i=1 for 3 cycles while if_pc_o=5 -> if_pc_o=5 and instr stable for all 3; after release sequence continues 6,7 with no gap or repeat.
- jmp_taken_i=1, target=0x0040 while if_pc_o=0x0010 -> next cycle if_valid_o=0, op_o=00, inst_o=10; following cycle if_pc_o=0x0040, then 0x0041.
- jmp_taken_i=1 and stall_i=1 same cycle, target=0x0020 -> jump taken; if_pc_o=0x0020 two edges later.
- RESET_PC=0xFFFE, free run -> if_pc_o 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst asserted during stall with if_pc_o=9 -> next edge if_valid_o=0, if_pc_o=0, if_instr_o=0; refetch from RESET_PC. With FETCH_PERF_EN, both counters also return to 0.
